kianv_phys_gateway: RTL and testbench

Physical-side memory gateway directly downstream of the SV32 MMU. It accepts 34-bit physical requests (bare-mode or translated), checks them against the platform physical memory map, and registers legal requests onto the 32-bit system bus. Illegal or timed-out requests return a one-cycle access-fault response with the RISC-V cause code, which the CSR and trap logic consume.

---
 rtl/kianv_phys_gateway.sv | 193 +++++++++++++++++++
 tb/tb_kianv_phys_gateway.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/kianv_phys_gateway.sv
// kianv_phys_gateway
// Physical-side gateway sitting directly below the SV32 MMU. A 34-bit
// physical request is checked against the platform memory map. A legal
// request is registered onto the 32-bit system bus. An illegal request, or one
// the bus never completes, gets a one-cycle access-fault response that carries
// the RISC-V cause code.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   up_valid/up_ready    MMU handshake; up_ready is a one-cycle completion pulse
//   up_wstrb/addr/wdata  request from MMU (wstrb==0 means read)
//   is_instruction       request is an instruction fetch
//   up_rdata             read data, valid with up_ready
//   up_fault/fault_cause access fault (1 fetch, 5 load, 7 store/AMO), with up_ready
//   fault_addr           low 32 address bits of the last faulting request
//   dn_valid/dn_ready    system bus handshake
//   dn_wstrb/addr/wdata  registered bus request, stable while dn_valid
//   dn_rdata             system bus read data
module kianv_phys_gateway #(
  parameter logic [31:0] RAM_BASE = 32'h8000_0000,
  parameter logic [31:0] RAM_SIZE = 32'h0200_0000,
  parameter logic [31:0] IO_BASE  = 32'h1000_0000,
  parameter logic [31:0] IO_SIZE  = 32'h1000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        up_valid,
  output logic        up_ready,
  input  logic [3:0]  up_wstrb,
  input  logic [33:0] up_addr,
  input  logic [31:0] up_wdata,
  output logic [31:0] up_rdata,
  input  logic        is_instruction,
  output logic        up_fault,
  output logic [3:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic        dn_valid,
  input  logic        dn_ready,
  output logic [3:0]  dn_wstrb,
  output logic [31:0] dn_addr,
  output logic [31:0] dn_wdata,
  input  logic [31:0] dn_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Last counter value before the request is abandoned; dn_valid is then
  // high for exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic        req_instr_r;
  logic        addr_legal_s;
  logic        timeout_s;

  // Region check done in 33 bits so a region ending at 2^32 does not wrap.
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] a33;
    logic [32:0] lo33;
    logic [32:0] hi33;
    a33  = {1'b0, a};
    lo33 = {1'b0, base};
    hi33 = {1'b0, base} + {1'b0, size};
    return (a33 >= lo33) && (a33 < hi33);
  endfunction

  // Cause priority: fetch, then store/AMO, then load.
  function automatic logic [3:0] cause_of(input logic instr, input logic [3:0] wstrb);
    logic [3:0] c;
    if (instr) begin
      c = 4'd1;
    end else if (|wstrb) begin
      c = 4'd7;
    end else begin
      c = 4'd5;
    end
    return c;
  endfunction

  // Legality of the incoming request; fetches from MMIO are never allowed.
  always_comb begin
    addr_legal_s = 1'b0;
    if (up_addr[33:32] == 2'b00) begin
      addr_legal_s = in_window(up_addr[31:0], RAM_BASE, RAM_SIZE) ||
                     (in_window(up_addr[31:0], IO_BASE, IO_SIZE) && !is_instruction);
    end else begin
      addr_legal_s = 1'b0;
    end
  end

  assign timeout_s = (cnt_r == TO_LAST);

  // Next-state logic; dn_ready takes priority over a simultaneous timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (up_valid) begin
          if (addr_legal_s) begin
            state_s = REQ;
          end else begin
            state_s = FAULT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (dn_ready) begin
          state_s = DONE;
        end else if (timeout_s) begin
          state_s = FAULT;
        end else begin
          state_s = REQ;
        end
      end
      DONE:    state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request, response and fault bookkeeping registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r       <= 8'd0;
      req_instr_r <= 1'b0;
      dn_wstrb    <= 4'd0;
      dn_addr     <= 32'd0;
      dn_wdata    <= 32'd0;
      up_rdata    <= 32'd0;
      fault_cause <= 4'd0;
      fault_addr  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 8'd0;
          if (up_valid) begin
            if (addr_legal_s) begin
              dn_wstrb    <= up_wstrb;
              dn_addr     <= up_addr[31:0];
              dn_wdata    <= up_wdata;
              req_instr_r <= is_instruction;
            end else begin
              fault_addr  <= up_addr[31:0];
              fault_cause <= cause_of(is_instruction, up_wstrb);
              up_rdata    <= 32'd0;
            end
          end
        end
        REQ: begin
          cnt_r <= cnt_r + 8'd1;
          if (dn_ready) begin
            up_rdata <= dn_rdata;
          end else if (timeout_s) begin
            fault_addr  <= dn_addr;
            fault_cause <= cause_of(req_instr_r, dn_wstrb);
            up_rdata    <= 32'd0;
          end
        end
        default: begin
          cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Handshake outputs are pure state decode; up_ready/up_fault are gated by
  // up_valid so an abandoned request produces no response.
  assign dn_valid = (state_r == REQ);
  assign up_ready = ((state_r == DONE) || (state_r == FAULT)) && up_valid;
  assign up_fault = (state_r == FAULT) && up_valid;

endmodule

// File: tb/tb_kianv_phys_gateway.sv
// Scoreboard bench for kianv_phys_gateway (TIMEOUT overridden to 4).
module tb_kianv_phys_gateway;

  localparam int TO = 4;

  logic        clk;
  logic        resetn;
  logic        up_valid;
  logic        up_ready;
  logic [3:0]  up_wstrb;
  logic [33:0] up_addr;
  logic [31:0] up_wdata;
  logic [31:0] up_rdata;
  logic        is_instruction;
  logic        up_fault;
  logic [3:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        dn_valid;
  logic        dn_ready;
  logic [3:0]  dn_wstrb;
  logic [31:0] dn_addr;
  logic [31:0] dn_wdata;
  logic [31:0] dn_rdata;

  kianv_phys_gateway #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .up_valid(up_valid), .up_ready(up_ready), .up_wstrb(up_wstrb),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_rdata(up_rdata),
    .is_instruction(is_instruction), .up_fault(up_fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_wstrb(dn_wstrb),
    .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_rdata(dn_rdata)
  );

  typedef struct {
    logic        fault;
    logic [3:0]  cause;
    logic [31:0] faddr;
    logic [31:0] rdata;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the gateway answers.
  always @(negedge clk) begin
    if (resetn && up_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", 64'(up_ready), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.tag, "_fault"}, 64'(up_fault), 64'(e.fault));
        chk({e.tag, "_rdata"}, 64'(up_rdata), 64'(e.rdata));
        chk({e.tag, "_cycle"}, 64'(cyc_cnt), 64'(e.cyc));
        if (e.fault) begin
          chk({e.tag, "_cause"}, 64'(fault_cause), 64'(e.cause));
          chk({e.tag, "_faddr"}, 64'(fault_addr), 64'(e.faddr));
        end
      end
    end
    if (resetn && !up_ready && up_fault) begin
      chk("fault_without_ready", 64'(up_fault), 64'd0);
    end
  end

  // One request. rdy_at: cycle (>=1) in which dn_ready is given, <=0 for never.
  // drop_at: cycle in which up_valid is withdrawn, <0 for never.
  task automatic run_req(input string tag, input logic [33:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input logic instr, input logic legal,
                         input int rdy_at, input logic [31:0] rdata, input int drop_at);
    exp_t e;
    int   exp_dn;
    int   dn_cnt;
    bit   done;
    exp_dn = !legal ? 0 : ((rdy_at > 0) ? rdy_at : TO);
    e.fault = !legal || (rdy_at <= 0);
    e.cause = instr ? 4'd1 : ((wstrb != 4'd0) ? 4'd7 : 4'd5);
    e.faddr = addr[31:0];
    e.rdata = e.fault ? 32'd0 : rdata;
    e.cyc   = cyc_cnt + exp_dn + 1;
    e.tag   = tag;
    if (drop_at < 0) sb_q.push_back(e);
    up_addr = addr; up_wstrb = wstrb; up_wdata = wdata;
    is_instruction = instr; up_valid = 1'b1;
    dn_cnt = 0;
    done = 1'b0;
    for (int c = 1; c <= 30 && !done; c++) begin
      @(posedge clk); #1;
      dn_ready = 1'b0;
      if (dn_valid) begin
        dn_cnt++;
        chk({tag, "_dn_addr"}, 64'(dn_addr), 64'(addr[31:0]));
        chk({tag, "_dn_wstrb"}, 64'(dn_wstrb), 64'(wstrb));
        chk({tag, "_dn_wdata"}, 64'(dn_wdata), 64'(wdata));
      end
      if (c == drop_at) up_valid = 1'b0;
      if (c == rdy_at) begin
        dn_ready = 1'b1;
        dn_rdata = rdata;
      end
      if (up_ready) done = 1'b1;
      if (drop_at >= 0 && c == rdy_at + 1) begin
        chk({tag, "_no_ready"}, 64'(up_ready), 64'd0);
        done = 1'b1;
      end
    end
    if (!done) chk({tag, "_no_response"}, 64'd0, 64'd1);
    chk({tag, "_dn_cycles"}, 64'(dn_cnt), 64'(exp_dn));
    @(posedge clk); #1;
    up_valid = 1'b0; dn_ready = 1'b0; up_wstrb = 4'd0; is_instruction = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [3:0]  rw;
    logic [31:0] saved_faddr;
    resetn = 1'b0; up_valid = 1'b0; up_wstrb = 4'd0; up_addr = 34'd0;
    up_wdata = 32'd0; is_instruction = 1'b0; dn_ready = 1'b0; dn_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_dn_addr", 64'(dn_addr), 64'd0);
    chk("rst_dn_wstrb", 64'(dn_wstrb), 64'd0);
    chk("rst_up_rdata", 64'(up_rdata), 64'd0);
    chk("rst_fault_cause", 64'(fault_cause), 64'd0);
    chk("rst_fault_addr", 64'(fault_addr), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_req("ram_read",    34'h0_8000_0010, 4'h0, 32'h0,         1'b0, 1'b1, 2, 32'hDEAD_BEEF, -1);
    run_req("upper_store", 34'h1_8000_0000, 4'hF, 32'h1111_2222, 1'b0, 1'b0, 0, 32'h0, -1);
    run_req("io_fetch",    34'h0_1000_0000, 4'h0, 32'h0,         1'b1, 1'b0, 0, 32'h0, -1);
    saved_faddr = 32'h1000_0000;
    run_req("io_load",     34'h0_1000_0000, 4'h0, 32'h0,         1'b0, 1'b1, 1, 32'h1234_5678, -1);
    chk("faddr_held", 64'(fault_addr), 64'(saved_faddr));
    run_req("timeout_ld",  34'h0_8000_0100, 4'h0, 32'h0,         1'b0, 1'b1, 0, 32'h0, -1);
    run_req("timeout_st",  34'h0_8000_0200, 4'h3, 32'hCAFE_0001, 1'b0, 1'b1, 0, 32'h0, -1);
    run_req("timeout_if",  34'h0_8000_0300, 4'h0, 32'h0,         1'b1, 1'b1, 0, 32'h0, -1);
    run_req("tie",         34'h0_8000_0400, 4'h0, 32'h0,         1'b0, 1'b1, TO, 32'hA5A5_5A5A, -1);
    run_req("ram_last",    34'h0_81FF_FFFC, 4'h0, 32'h0,         1'b0, 1'b1, 1, 32'h0BAD_F00D, -1);
    run_req("ram_end",     34'h0_8200_0000, 4'h0, 32'h0,         1'b0, 1'b0, 0, 32'h0, -1);
    run_req("ram_below",   34'h0_7FFF_FFFC, 4'h1, 32'h5,         1'b0, 1'b0, 0, 32'h0, -1);
    run_req("io_last",     34'h0_1FFF_FFFC, 4'hC, 32'h7777_8888, 1'b0, 1'b1, 3, 32'h0, -1);
    run_req("io_end",      34'h0_2000_0000, 4'h0, 32'h0,         1'b0, 1'b0, 0, 32'h0, -1);
    run_req("ram_fetch",   34'h0_8000_0800, 4'h0, 32'h0,         1'b1, 1'b1, 1, 32'h0000_0013, -1);
    run_req("drop_write",  34'h0_8000_0020, 4'hF, 32'hFEED_FACE, 1'b0, 1'b1, 3, 32'h0, 2);

    for (int i = 0; i < 6; i++) begin
      ra = 32'h8000_0000 + ($urandom & 32'h01FF_FFFC);
      rw = 4'($urandom_range(0, 15));
      run_req("rand", {2'b00, ra}, rw, $urandom, 1'b0, 1'b1, $urandom_range(1, 3), $urandom, -1);
    end

    // Reset while the bus request is outstanding.
    up_addr = 34'h0_8000_0040; up_wstrb = 4'h0; is_instruction = 1'b0; up_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_req_valid", 64'(dn_valid), 64'd1);
    #2 resetn = 1'b0; up_valid = 1'b0;
    #1;
    chk("rst_mid_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_mid_dn_addr", 64'(dn_addr), 64'd0);
    #3 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_quiet", 64'({up_ready, dn_valid}), 64'd0);
    end
    run_req("after_rst",   34'h0_8000_0044, 4'h0, 32'h0,         1'b0, 1'b1, 1, 32'h3C3C_3C3C, -1);

    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
